rgb_led_ctrl: RTL and testbench
===============================

Name: rgb_led_ctrl

Overview:
- Parametrised multi-LED RGB indicator controller.
- Commands select a colour and mode for each common-anode LED.
- One shared brightness level drives a free-running PWM. Modes are off, solid, blink, and timed pulse.
- Drives the board status LEDs from the bot's task FSM. Supersedes the single-LED, three-colour combinational indicator.

Parameters:
- NUM_LEDS, 2, number of RGB LEDs driven.
- IDX_W, 1, width of the LED index; must satisfy 2**IDX_W >= NUM_LEDS.
- PWM_BITS, 8, width of the PWM counter and of the brightness value.
- BLINK_HALF, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz).
- PULSE_CYCLES, 50000000, clock cycles a pulse-mode colour is shown.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset: synchronous, active-low.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_idx  in  IDX_W  target LED.
- cmd_color  in  3  colour code.
- cmd_mode  in  2  0 = off, 1 = solid, 2 = blink, 3 = pulse.
- bright_we  in  1  loads the brightness value.
- bright_in  in  PWM_BITS  new PWM duty.
- cmd_err  out  1  one-cycle pulse on a rejected command.
- r  out  NUM_LEDS  red drive, active-low.
- g  out  NUM_LEDS  green drive, active-low.
- b  out  NUM_LEDS  blue drive, active-low.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - r, g and b are all 1; cmd_ready = 0; cmd_err = 0.
  - Every LED goes to colour 0, mode off; brightness is set to all ones.
  - PWM counter, blink prescaler, blink phase and pulse counters clear to 0.
  - Reset asserted mid-pulse or mid-blink aborts immediately; nothing is resumed.
- cmd_ready is registered. It goes to 1 on the first edge with rst = 1 and then stays 1. Accept = cmd_valid & cmd_ready.
- Colour codes (bit2:bit1:bit0 = b:g:r are not used; the fixed map below applies):
  - 0 = none, 1 = red, 2 = green, 3 = blue.
  - 4 = red + green, 5 = green + blue, 6 = red + blue, 7 = all three.
  - Every code is defined; no code holds the previous output.
- Command accepted at edge N updates that LED's colour and mode registers at edge N.
  - The drive outputs are registered, so the change is visible after edge N+1 (latency 2 cycles from cmd_valid).
- cmd_idx >= NUM_LEDS: no state changes, and cmd_err = 1 for exactly one cycle after the edge.
- The same LED commanded on consecutive cycles: the last command wins. Pulse mode restarts its counter on every accepted pulse command.
- PWM:
  - pwm_cnt increments every cycle and wraps from 2**PWM_BITS - 1 to 0.
  - pwm_on = (pwm_cnt < bright).
  - bright = 0: LEDs are never lit. bright = all ones: lit 255 of every 256 cycles (PWM_BITS = 8).
- bright_we:
  - Loads bright at the edge.
  - Takes effect on the next pwm_cnt comparison; no glitch suppression is required.
  - Independent of cmd_valid; both may occur in the same cycle.
- Blink:
  - A global prescaler counts 0 to BLINK_HALF - 1, then wraps and toggles blink_ph.
  - A blink LED is lit only while blink_ph = 1; all blinking LEDs are phase-locked.
- Pulse:
  - A per-LED counter loads PULSE_CYCLES - 1 on accept and decrements each cycle while the mode is pulse.
  - At 0, the mode becomes off on the next edge (the colour is retained). A lit window is exactly PULSE_CYCLES cycles.
- Lit condition: lit_i = pwm_on & (mode = solid | (mode = blink & blink_ph) | mode = pulse).
  - Channel output = ~(lit_i & colour bit for that channel).
- Off mode forces all three channels of that LED to 1, regardless of colour.

Decomposition:
- Package rgb_led_pkg holds:
  - MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_PULSE.
  - Named colour constants COL_NONE through COL_WHITE.
  - The colour-to-RGB mask function.
- Sub-module rgb_led_chan: one per LED, generated NUM_LEDS times.
  - Contains the colour/mode registers, the pulse counter and the registered active-low drive.
  - Shares pwm_on and blink_ph from the top level.

Test Plan:
- Reset test: hold rst = 0 for 3 cycles with cmd_valid = 1 -> r = g = b = 2'b11, cmd_ready = 0, no state change. Release reset -> cmd_ready = 1 after one edge.
- Solid test: bright = 8'hFF; cmd idx 0, colour 1, mode solid -> r[0] low 255 of 256 cycles starting 2 cycles after the command; g[0] = b[0] = 1; LED 1 untouched.
- PWM test: bright = 8'h40, colour 7, mode solid on LED 1 -> r[1], g[1] and b[1] each low exactly 64 of every 256 cycles. bright = 0 -> constantly 1.
- Blink test (BLINK_HALF = 10): colour 2, mode blink -> g low (PWM-gated) for 10 cycles and high for 10, repeating; a second LED in blink is phase-aligned.
- Pulse test (PULSE_CYCLES = 20): colour 3, mode pulse -> b lit for exactly 20 cycles, then 1 with the mode read back as off. Re-issuing the pulse at cycle 15 extends the window to 35 cycles in total.
- Error/reset-abort test: cmd_idx = 3 with NUM_LEDS = 2 -> cmd_err high for one cycle and no outputs change. rst = 0 during a pulse -> outputs go to 1 the next edge and the pulse does not resume after release.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Shared mode/colour encodings and the colour-code to RGB channel mask.
package rgb_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PULSE = 2'd3
   } mode_t;

   localparam logic [2:0] COL_NONE    = 3'd0;
   localparam logic [2:0] COL_RED     = 3'd1;
   localparam logic [2:0] COL_GREEN   = 3'd2;
   localparam logic [2:0] COL_BLUE    = 3'd3;
   localparam logic [2:0] COL_YELLOW  = 3'd4;
   localparam logic [2:0] COL_CYAN    = 3'd5;
   localparam logic [2:0] COL_MAGENTA = 3'd6;
   localparam logic [2:0] COL_WHITE   = 3'd7;

   // Returns {blue, green, red}; the code is a lookup, not a bit-field.
   function automatic logic [2:0] color_mask(input logic [2:0] code);
      logic [2:0] m;
      case (code)
         COL_NONE:    m = 3'b000;
         COL_RED:     m = 3'b001;
         COL_GREEN:   m = 3'b010;
         COL_BLUE:    m = 3'b100;
         COL_YELLOW:  m = 3'b011;
         COL_CYAN:    m = 3'b110;
         COL_MAGENTA: m = 3'b101;
         default:     m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rgb_led_chan.sv
// One RGB LED: colour/mode registers, pulse timer and registered active-low drive.
// Shares pwm_on and blink_ph from the top level so all LEDs stay phase-locked.
module rgb_led_chan
   import rgb_led_pkg::*;
#(
   parameter int PULSE_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [2:0] color_in,
   input  logic [1:0] mode_in,
   input  logic       pwm_on,
   input  logic       blink_ph,
   output logic       r,
   output logic       g,
   output logic       b
);

   localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

   logic [2:0]       color;
   mode_t            mode;
   logic [CNT_W-1:0] cnt;
   logic             lit;
   logic [2:0]       mask;

   assign mask = color_mask(color);
   assign lit  = pwm_on & ((mode == MODE_SOLID) |
                           ((mode == MODE_BLINK) & blink_ph) |
                           (mode == MODE_PULSE));

   always_ff @(posedge clk) begin
      if (!rst) begin
         color <= COL_NONE;
         mode  <= MODE_OFF;
         cnt   <= '0;
         r     <= 1'b1;
         g     <= 1'b1;
         b     <= 1'b1;
      end else begin
         // A new command always wins, restarting any pulse in progress.
         if (load) begin
            color <= color_in;
            mode  <= mode_t'(mode_in);
            cnt   <= CNT_LOAD;
         end else if (mode == MODE_PULSE) begin
            if (cnt == '0)
               mode <= MODE_OFF;
            else
               cnt <= cnt - CNT_W'(1);
         end
         r <= ~(lit & mask[0]);
         g <= ~(lit & mask[1]);
         b <= ~(lit & mask[2]);
      end
   end

endmodule

// File: rtl/rgb_led_ctrl.sv
// Multi-LED RGB controller: shared PWM brightness and blink phase, per-LED command state.
// Commands take effect on the accepting edge; drives change one edge later.
module rgb_led_ctrl
   import rgb_led_pkg::*;
#(
   parameter int NUM_LEDS     = 2,
   parameter int IDX_W        = 1,
   parameter int PWM_BITS     = 8,
   parameter int BLINK_HALF   = 25000000,
   parameter int PULSE_CYCLES = 50000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IDX_W-1:0]    cmd_idx,
   input  logic [2:0]          cmd_color,
   input  logic [1:0]          cmd_mode,
   input  logic                bright_we,
   input  logic [PWM_BITS-1:0] bright_in,
   output logic                cmd_err,
   output logic [NUM_LEDS-1:0] r,
   output logic [NUM_LEDS-1:0] g,
   output logic [NUM_LEDS-1:0] b
);

   localparam int PRE_W = $clog2(BLINK_HALF + 1);
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(BLINK_HALF - 1);
   localparam logic [IDX_W:0]   NUM_LIM  = (IDX_W + 1)'(NUM_LEDS);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] bright;
   logic [PRE_W-1:0]    presc;
   logic                blink_ph;
   logic                pwm_on;
   logic                accept;
   logic                idx_ok;

   assign accept = cmd_valid & cmd_ready;
   assign idx_ok = ({1'b0, cmd_idx} < NUM_LIM);
   assign pwm_on = (pwm_cnt < bright);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cmd_ready <= 1'b0;
         cmd_err   <= 1'b0;
         pwm_cnt   <= '0;
         bright    <= '1;
         presc     <= '0;
         blink_ph  <= 1'b0;
      end else begin
         cmd_ready <= 1'b1;
         cmd_err   <= accept & ~idx_ok;
         pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
         if (bright_we)
            bright <= bright_in;
         if (presc == PRE_MAX) begin
            presc    <= '0;
            blink_ph <= ~blink_ph;
         end else begin
            presc <= presc + PRE_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
      rgb_led_chan #(
         .PULSE_CYCLES(PULSE_CYCLES)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .load     (accept & idx_ok & (cmd_idx == IDX_W'(i))),
         .color_in (cmd_color),
         .mode_in  (cmd_mode),
         .pwm_on   (pwm_on),
         .blink_ph (blink_ph),
         .r        (r[i]),
         .g        (g[i]),
         .b        (b[i])
      );
   end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Randomised and directed bench for rgb_led_ctrl against a time-based behavioural model.
module tb_rgb_led_ctrl;

   localparam int NL = 2;
   localparam int BH = 10;
   localparam int PC = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_idx = 2'd0;
   logic [2:0] cmd_color = 3'd0;
   logic [1:0] cmd_mode = 2'd0;
   logic       bright_we = 1'b0;
   logic [7:0] bright_in = 8'd0;
   logic       cmd_err;
   logic [1:0] r, g, b;

   rgb_led_ctrl #(
      .NUM_LEDS(NL), .IDX_W(2), .PWM_BITS(8), .BLINK_HALF(BH), .PULSE_CYCLES(PC)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_idx(cmd_idx), .cmd_color(cmd_color), .cmd_mode(cmd_mode),
      .bright_we(bright_we), .bright_in(bright_in), .cmd_err(cmd_err),
      .r(r), .g(g), .b(b)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Colour code -> channel membership.
   int red_m[8] = '{0, 1, 0, 0, 1, 0, 1, 1};
   int grn_m[8] = '{0, 0, 1, 0, 1, 1, 0, 1};
   int blu_m[8] = '{0, 0, 0, 1, 0, 1, 1, 1};

   // Model: counters expressed as time since reset; pulse as accept-edge timestamp.
   int   t = 0;
   int   edge_n = 0;
   int   m_bright = 255;
   int   m_col[NL];
   int   m_mode[NL];
   int   m_acc[NL];
   logic [1:0] m_r = 2'b11, m_g = 2'b11, m_b = 2'b11;
   logic m_ready = 1'b0, m_err = 1'b0;
   bit   m_seen = 0;
   bit   lit;

   always @(posedge clk) begin
      edge_n++;
      m_seen = 1;
      if (!rst) begin
         t = 0;
         m_bright = 255;
         m_r = 2'b11; m_g = 2'b11; m_b = 2'b11;
         m_ready = 1'b0; m_err = 1'b0;
         for (int i = 0; i < NL; i++) begin
            m_col[i] = 0; m_mode[i] = 0; m_acc[i] = 0;
         end
      end else begin
         for (int i = 0; i < NL; i++) begin
            lit = ((t % 256) < m_bright) &&
                  (m_mode[i] == 1 || (m_mode[i] == 2 && ((t / BH) % 2) == 1) || m_mode[i] == 3);
            m_r[i] = !(lit && red_m[m_col[i]] == 1);
            m_g[i] = !(lit && grn_m[m_col[i]] == 1);
            m_b[i] = !(lit && blu_m[m_col[i]] == 1);
         end
         for (int i = 0; i < NL; i++)
            if (m_mode[i] == 3 && edge_n - m_acc[i] >= PC) m_mode[i] = 0;
         m_err = m_ready && cmd_valid && (int'(cmd_idx) >= NL);
         if (m_ready && cmd_valid && int'(cmd_idx) < NL) begin
            m_col[cmd_idx]  = int'(cmd_color);
            m_mode[cmd_idx] = int'(cmd_mode);
            m_acc[cmd_idx]  = edge_n;
         end
         if (bright_we) m_bright = int'(bright_in);
         m_ready = 1'b1;
         t++;
      end
   end

   always @(negedge clk) begin
      if (m_seen) begin
         n_total++;
         if ({r, g, b, cmd_ready, cmd_err} === {m_r, m_g, m_b, m_ready, m_err})
            n_pass++;
         else
            $display("FAIL model_cmp t=%0t got r=%b g=%b b=%b rdy=%b err=%b want r=%b g=%b b=%b rdy=%b err=%b",
                     $time, r, g, b, cmd_ready, cmd_err, m_r, m_g, m_b, m_ready, m_err);
      end
   end

   task automatic check_eq(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s got %0d want %0d", name, act, exp);
   endtask

   task automatic send(input int idx, input int col, input int mode);
      cmd_valid = 1'b1;
      cmd_idx   = 2'(idx);
      cmd_color = 3'(col);
      cmd_mode  = 2'(mode);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic set_bright(input int v);
      bright_we = 1'b1;
      bright_in = 8'(v);
      @(negedge clk);
      bright_we = 1'b0;
   endtask

   // sel: 0/1 = r[i], 2/3 = g[i-2], 4/5 = b[i-4]
   task automatic count_low(input int n, input int sel, output int lows);
      logic [5:0] v;
      lows = 0;
      for (int i = 0; i < n; i++) begin
         v = {b, g, r};
         if (v[sel] == 1'b0) lows++;
         @(negedge clk);
      end
   endtask

   int lows;
   int mism;

   initial begin
      // Reset held with a command pending.
      cmd_valid = 1'b1; cmd_idx = 2'd0; cmd_color = 3'd7; cmd_mode = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("reset_rgb", int'({r, g, b}), 6'h3F);
         check_eq("reset_ready", int'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_eq("ready_after_release", int'(cmd_ready), 1);
      @(negedge clk);

      // Solid red on LED 0 at full brightness.
      send(0, 1, 1);
      check_eq("solid_latency_hold", int'(r[0]), 1);
      repeat (3) @(negedge clk);
      count_low(256, 0, lows); check_eq("solid_r0_lows", lows, 255);
      count_low(256, 2, lows); check_eq("solid_g0_lows", lows, 0);
      count_low(256, 1, lows); check_eq("solid_led1_untouched", lows, 0);

      // PWM duty.
      set_bright(8'h40);
      send(1, 7, 1);
      repeat (3) @(negedge clk);
      count_low(256, 1, lows); check_eq("pwm40_r1", lows, 64);
      count_low(256, 3, lows); check_eq("pwm40_g1", lows, 64);
      count_low(256, 5, lows); check_eq("pwm40_b1", lows, 64);
      set_bright(0);
      repeat (3) @(negedge clk);
      count_low(256, 1, lows); check_eq("pwm0_r1", lows, 0);

      // Blink, both LEDs green.
      set_bright(8'hFF);
      send(0, 2, 2);
      send(1, 2, 2);
      repeat (3) @(negedge clk);
      mism = 0;
      for (int i = 0; i < 40; i++) begin
         if (g[0] != g[1]) mism++;
         @(negedge clk);
      end
      check_eq("blink_phase_lock", mism, 0);
      count_low(2560, 2, lows); check_eq("blink_g0_lows", lows, 1274);

      // Rejected index.
      send(3, 7, 1);
      check_eq("err_pulse", int'(cmd_err), 1);
      @(negedge clk);
      check_eq("err_one_cycle", int'(cmd_err), 0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_idx   = 2'($urandom_range(0, 3));
         cmd_color = 3'($urandom_range(0, 7));
         cmd_mode  = 2'($urandom_range(0, 3));
         bright_we = ($urandom_range(0, 31) == 0);
         bright_in = 8'($urandom_range(0, 255));
         rst       = ($urandom_range(0, 999) != 0);
         @(negedge clk);
      end
      cmd_valid = 1'b0; bright_we = 1'b0;

      // Fresh reset so pulse windows avoid the PWM off slot.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      send(0, 3, 3);
      count_low(50, 4, lows); check_eq("pulse_window", lows, 20);
      count_low(20, 4, lows); check_eq("pulse_stays_off", lows, 0);

      send(1, 3, 3);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         if (b[1] == 1'b0) lows++;
         if (i == 14) begin
            cmd_valid = 1'b1; cmd_idx = 2'd1; cmd_color = 3'd3; cmd_mode = 2'd3;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      check_eq("pulse_extended", lows, 35);

      // Reset mid-pulse.
      send(0, 3, 3);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_b0_high", int'(b[0]), 1);
      @(negedge clk);
      rst = 1'b1;
      count_low(40, 4, lows); check_eq("abort_no_resume", lows, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
